dvs_event_fifo: RTL and testbench
=================================

// Module: dvs_event_fifo
// PURPOSE
//   Parametrised event FIFO with threshold-hysteresis interrupt and overflow accounting.
//   It sits between the DVS event path (writer) and the SPI/regfile read path (reader).
//   The regfile supplies the thresholds, the clear pulses and the read strobe.
//   Generalises the fixed-width FIFO: data width and depth are parametrised, and it adds
//   hysteresis bypass, IRQ disable, a soft clear and a saturating overflow count.
// PARAMETERS
//   DWIDTH   32   data word width in bits
//   AWIDTH   5    address width; DEPTH = 2**AWIDTH words
//   OVF_W    16   overflow counter width, saturating
// PORTS
//   clk                  in   1         system clock
//   rst                  in   1         synchronous reset, active-high
//   soft_clr             in   1         1-cycle pulse from regfile; empties the FIFO
//   wr_valid             in   1         write request
//   wr_data              in   DWIDTH    write data
//   wr_ready             out  1         = !full
//   rd_en                in   1         read strobe
//   rd_data              out  DWIDTH    registered read data
//   rd_valid             out  1         1-cycle pulse; rd_data is valid in that cycle
//   irq_assert_thresh    in   AWIDTH+1  IRQ sets when numel >= this value; 0 disables IRQ
//   irq_deassert_thresh  in   AWIDTH+1  IRQ clears when numel <= this value
//   numel                out  AWIDTH+1  current occupancy, range 0..DEPTH
//   full, empty          out  1         numel==DEPTH / numel==0
//   irq                  out  1         registered interrupt
//   ovf_sticky           out  1         set on any dropped write
//   ovf_cnt              out  OVF_W     count of dropped writes, saturates at all-ones
//   ovf_clr              in   1         clears ovf_sticky and ovf_cnt
// BEHAVIOUR
// - Reset values on rst: wr/rd pointers=0, numel=0, empty=1, full=0, wr_ready=1,
//   rd_valid=0, rd_data=0, irq=0, ovf_sticky=0, ovf_cnt=0.
// - Write: accepted on an edge where wr_valid && !full. Data is stored and wr_ptr++,
//   wrapping modulo DEPTH.
// - Write while full: data is dropped; ovf_sticky<=1; ovf_cnt++ (saturating).
//   FIFO contents are unchanged.
// - Read: accepted on an edge where rd_en && !empty. rd_data<=mem[rd_ptr]; rd_valid=1
//   for exactly the next cycle; rd_ptr++ with wrap.
// - Read while empty: ignored; rd_valid=0; rd_data holds its last value.
// - Simultaneous read and write:
//     - not full and not empty: both happen, numel unchanged, order preserved.
//     - full: the read is accepted, the write is dropped and counted (wr_ready was 0).
//     - empty: the write is accepted, the read is ignored; there is no bypass.
// - numel, full and empty are registered and update on the same edge as the pointers.
// - IRQ is a 2-state FSM (IDLE/ASSERTED) evaluated on the registered numel, so irq lags
//   numel by 1 cycle.
//     - IDLE -> ASSERTED when numel >= assert_thresh.
//     - ASSERTED -> IDLE when numel <= deassert_thresh.
//     - assert_thresh == 0: irq forced 0 and FSM held in IDLE.
//     - assert_thresh <= deassert_thresh: hysteresis bypassed; irq <= (numel >= assert_thresh).
//     - Threshold changes take effect on the next evaluation.
// - soft_clr: pointers=0, numel=0, irq=0 (IDLE), rd_valid=0. ovf_* are unaffected.
//     - It has priority over a concurrent wr/rd; both are discarded.
//     - A write discarded by soft_clr is not counted as an overflow.
// - ovf_clr coincident with a dropped write: the clear applies first, then the increment,
//   giving ovf_cnt=1 and ovf_sticky=1.
// - rst overrides soft_clr and ovf_clr. rst mid-operation aborts any read; no rd_valid follows.
// TESTING  (bench uses AWIDTH=3, i.e. DEPTH=8)
// 1 Fill/drain: write 0xA0..0xA7 -> numel=8, full=1, wr_ready=0. Read 8 ->
//   0xA0..0xA7 in order, each with rd_valid 1 cycle after rd_en; final empty=1.
// 2 Hysteresis, assert=6 / deassert=2: write 6 -> irq=1 one cycle after numel=6.
//   Read down to 3 -> irq stays 1. At numel=2 -> irq=0 next cycle.
// 3 Overflow: fill 8, then 3 more writes -> ovf_cnt=3, ovf_sticky=1, contents intact.
//   ovf_clr pulse -> ovf_cnt=0, ovf_sticky=0.
// 4 Concurrent access: rd_en+wr_valid at numel=4 -> numel stays 4, order kept.
//   At empty -> rd_valid=0, numel=1.
// 5 soft_clr at numel=5 with irq=1 and a concurrent write -> numel=0, empty=1, irq=0,
//   ovf_cnt unchanged.
// 6 Config edge cases: assert=0 with numel=8 -> irq stays 0. assert=3, deassert=5 ->
//   irq follows (numel>=3) with 1-cycle lag. rst mid-read -> all reset values next edge.

Source files
------------

// File: rtl/dvs_event_fifo.sv
// Event FIFO between the DVS event writer and the SPI/regfile reader.
// Adds a threshold-hysteresis interrupt, a soft clear and saturating overflow accounting.
module dvs_event_fifo #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned OVF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_clr,
  input  logic              wr_valid,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  input  logic [AWIDTH:0]   irq_assert_thresh,
  input  logic [AWIDTH:0]   irq_deassert_thresh,
  output logic [AWIDTH:0]   numel,
  output logic              full,
  output logic              empty,
  output logic              irq,
  output logic              ovf_sticky,
  output logic [OVF_W-1:0]  ovf_cnt,
  input  logic              ovf_clr
);

  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam int unsigned CW    = AWIDTH + 1;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_ASSERTED = 1'b1
  } irq_state_t;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;

  logic              wr_acc;
  logic              rd_acc;
  logic              wr_drop;
  logic [CW-1:0]     numel_nxt;
  logic [OVF_W-1:0]  ovf_base;
  logic [OVF_W-1:0]  ovf_cnt_nxt;
  logic              ovf_sticky_nxt;

  irq_state_t        state_q;
  irq_state_t        state_d;

  // Accept/drop qualification; soft_clr discards both sides and hides the drop.
  always_comb begin
    wr_acc  = wr_valid & ~full  & ~soft_clr;
    rd_acc  = rd_en    & ~empty & ~soft_clr;
    wr_drop = wr_valid &  full  & ~soft_clr;
  end

  // Next occupancy and overflow accounting; ovf_clr applies before a coincident increment.
  always_comb begin
    numel_nxt      = numel;
    ovf_base       = ovf_cnt;
    ovf_cnt_nxt    = ovf_cnt;
    ovf_sticky_nxt = ovf_sticky;

    if (soft_clr) begin
      numel_nxt = '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   numel_nxt = numel + CW'(1);
        2'b01:   numel_nxt = numel - CW'(1);
        default: numel_nxt = numel;
      endcase
    end

    if (ovf_clr) begin
      ovf_base       = '0;
      ovf_sticky_nxt = 1'b0;
    end
    ovf_cnt_nxt = ovf_base;
    if (wr_drop) begin
      ovf_sticky_nxt = 1'b1;
      if (ovf_base != {OVF_W{1'b1}}) begin
        ovf_cnt_nxt = ovf_base + OVF_W'(1);
      end
    end
  end

  // Storage array; written only on accepted writes.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, status flags, read port and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      numel      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      wr_ready   <= 1'b1;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      numel      <= numel_nxt;
      full       <= (numel_nxt == CW'(DEPTH));
      empty      <= (numel_nxt == '0);
      wr_ready   <= (numel_nxt != CW'(DEPTH));
      rd_valid   <= rd_acc;
      ovf_sticky <= ovf_sticky_nxt;
      ovf_cnt    <= ovf_cnt_nxt;
      if (soft_clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + AWIDTH'(1);
        end
        if (rd_acc) begin
          rd_ptr  <= rd_ptr + AWIDTH'(1);
          rd_data <= mem[rd_ptr];
        end
      end
    end
  end

  // IRQ state register; irq mirrors the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      irq     <= 1'b0;
    end else begin
      state_q <= state_d;
      irq     <= (state_d == ST_ASSERTED);
    end
  end

  // IRQ next-state on the registered occupancy; a non-positive hysteresis window degenerates to a compare.
  always_comb begin
    state_d = state_q;
    if (soft_clr || (irq_assert_thresh == '0)) begin
      state_d = ST_IDLE;
    end else if (irq_assert_thresh <= irq_deassert_thresh) begin
      state_d = (numel >= irq_assert_thresh) ? ST_ASSERTED : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (numel >= irq_assert_thresh) state_d = ST_ASSERTED;
        end
        ST_ASSERTED: begin
          if (numel <= irq_deassert_thresh) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dvs_event_fifo.sv
// Self-checking bench for dvs_event_fifo (DEPTH=8, 4-bit overflow counter).
module tb_dvs_event_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned OW    = 4;
  localparam int          DEPTH = 8;
  localparam int          OMAX  = 15;

  logic          clk;
  logic          rst;
  logic          soft_clr;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   thr_a;
  logic [AW:0]   thr_d;
  logic [AW:0]   numel;
  logic          full;
  logic          empty;
  logic          irq;
  logic          ovf_sticky;
  logic [OW-1:0] ovf_cnt;
  logic          ovf_clr;

  dvs_event_fifo #(.DWIDTH(DW), .AWIDTH(AW), .OVF_W(OW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .soft_clr            (soft_clr),
    .wr_valid            (wr_valid),
    .wr_data             (wr_data),
    .wr_ready            (wr_ready),
    .rd_en               (rd_en),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .irq_assert_thresh   (thr_a),
    .irq_deassert_thresh (thr_d),
    .numel               (numel),
    .full                (full),
    .empty               (empty),
    .irq                 (irq),
    .ovf_sticky          (ovf_sticky),
    .ovf_cnt             (ovf_cnt),
    .ovf_clr             (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wv;
    logic [31:0] wd;
    bit          re;
    bit          sc;
    logic [3:0]  ta;
    logic [3:0]  td;
    int          en;
    bit          ei;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_rd[$];
  bit            m_irq;
  int            m_ovf;
  bit            m_sticky;
  bit            m_rv;
  logic [DW-1:0] m_rd_data;
  int            errors;
  int            checks;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(bit wv, logic [31:0] wd, bit re, bit sc,
                              logic [3:0] ta, logic [3:0] td, int en, bit ei);
    vec_t v;
    v.wv = wv; v.wd = wd; v.re = re; v.sc = sc;
    v.ta = ta; v.td = td; v.en = en; v.ei = ei;
    tbl.push_back(v);
  endfunction

  // One clock of stimulus; model is advanced from pre-edge occupancy and all outputs compared.
  task automatic step(input bit r, input bit wv, input logic [DW-1:0] wd,
                      input bit re, input bit sc, input bit oc);
    int n;
    bit drop;
    rst = r; wr_valid = wv; wr_data = wd; rd_en = re; soft_clr = sc; ovf_clr = oc;
    n = mq.size();
    @(posedge clk);
    if (r) begin
      mq.delete(); exp_rd.delete();
      m_irq = 0; m_ovf = 0; m_sticky = 0; m_rv = 0; m_rd_data = '0;
    end else begin
      if (sc || thr_a == 0)           m_irq = 0;
      else if (thr_a <= thr_d)        m_irq = (n >= int'(thr_a));
      else if (!m_irq)                m_irq = (n >= int'(thr_a));
      else                            m_irq = !(n <= int'(thr_d));
      drop = wv && (n == DEPTH) && !sc;
      m_rv = 0;
      if (sc) begin
        mq.delete();
      end else begin
        if (re && n > 0) begin
          m_rd_data = mq.pop_front();
          exp_rd.push_back(m_rd_data);
          m_rv = 1;
        end
        if (wv && n < DEPTH) mq.push_back(wd);
      end
      if (oc) begin m_ovf = 0; m_sticky = 0; end
      if (drop) begin
        m_ovf = (m_ovf == OMAX) ? OMAX : m_ovf + 1;
        m_sticky = 1;
      end
    end
    #1;
    chk("numel",      64'(numel),      64'(mq.size()));
    chk("full",       64'(full),       64'(mq.size() == DEPTH));
    chk("empty",      64'(empty),      64'(mq.size() == 0));
    chk("wr_ready",   64'(wr_ready),   64'(mq.size() != DEPTH));
    chk("irq",        64'(irq),        64'(m_irq));
    chk("ovf_cnt",    64'(ovf_cnt),    64'(m_ovf));
    chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
    chk("rd_valid",   64'(rd_valid),   64'(m_rv));
    if (rd_valid === 1'b1) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 64'(1), 64'(0));
      else                    chk("rd_data", 64'(rd_data), 64'(exp_rd.pop_front()));
    end else begin
      chk("rd_data_hold", 64'(rd_data), 64'(m_rd_data));
    end
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0);
  endtask

  initial begin
    errors = 0; checks = 0;
    m_irq = 0; m_ovf = 0; m_sticky = 0; m_rv = 0; m_rd_data = '0;
    thr_a = '0; thr_d = '0;
    rst = 1; soft_clr = 0; wr_valid = 0; wr_data = '0; rd_en = 0; ovf_clr = 0;

    // reset state
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    chk("rst_numel", 64'(numel), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full",  64'(full),  64'(0));
    chk("rst_ready", 64'(wr_ready), 64'(1));
    chk("rst_rdata", 64'(rd_data), 64'(0));
    chk("rst_irq",   64'(irq), 64'(0));

    // fill/drain
    for (int i = 0; i < 8; i++) add(1, 32'hA0 + 32'(i), 0, 0, 0, 0, i + 1, 0);
    for (int i = 0; i < 8; i++) add(0, '0, 1, 0, 0, 0, 7 - i, 0);
    // hysteresis 6/2
    for (int i = 0; i < 6; i++) add(1, 32'h10 + 32'(i), 0, 0, 6, 2, i + 1, 0);
    add(0, '0, 0, 0, 6, 2, 6, 1);
    for (int i = 0; i < 4; i++) add(0, '0, 1, 0, 6, 2, 5 - i, 1);
    add(0, '0, 0, 0, 6, 2, 2, 0);
    add(0, '0, 1, 0, 6, 2, 1, 0);
    add(0, '0, 1, 0, 6, 2, 0, 0);
    // concurrent access
    for (int i = 0; i < 4; i++) add(1, 32'hB0 + 32'(i), 0, 0, 0, 0, i + 1, 0);
    add(1, 32'hC0, 1, 0, 0, 0, 4, 0);
    add(1, 32'hC1, 1, 0, 0, 0, 4, 0);
    for (int i = 0; i < 4; i++) add(0, '0, 1, 0, 0, 0, 3 - i, 0);
    add(1, 32'hD0, 1, 0, 0, 0, 1, 0);
    add(0, '0, 1, 0, 0, 0, 0, 0);
    // soft_clr with irq set and a concurrent write
    for (int i = 0; i < 5; i++) add(1, 32'hE0 + 32'(i), 0, 0, 4, 1, i + 1, (i == 4));
    add(1, 32'hF0, 0, 1, 4, 1, 0, 0);
    add(0, '0, 0, 0, 4, 1, 0, 0);

    foreach (tbl[k]) begin
      thr_a = tbl[k].ta;
      thr_d = tbl[k].td;
      step(0, tbl[k].wv, tbl[k].wd, tbl[k].re, tbl[k].sc, 0);
      chk("tbl_numel", 64'(numel), 64'(tbl[k].en));
      chk("tbl_irq",   64'(irq),   64'(tbl[k].ei));
    end

    // overflow accounting and saturation
    thr_a = '0; thr_d = '0;
    for (int i = 0; i < 8; i++) step(0, 1, 32'h30 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h99, 0, 0, 0);
    chk("ovf_cnt3", 64'(ovf_cnt), 64'(3));
    chk("ovf_sticky3", 64'(ovf_sticky), 64'(1));
    step(0, 0, '0, 0, 0, 1);
    chk("ovf_clr_cnt", 64'(ovf_cnt), 64'(0));
    chk("ovf_clr_sticky", 64'(ovf_sticky), 64'(0));
    step(0, 1, 32'h99, 0, 0, 1);
    chk("ovf_clr_drop", 64'(ovf_cnt), 64'(1));
    step(0, 1, 32'h77, 1, 0, 0);
    chk("full_rdwr_numel", 64'(numel), 64'(7));
    chk("full_rdwr_ovf", 64'(ovf_cnt), 64'(2));
    step(0, 1, 32'h38, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 32'h99, 0, 0, 0);
    chk("ovf_sat", 64'(ovf_cnt), 64'(OMAX));
    step(0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 32'h50 + 32'(i), 0, 0, 0);
    step(0, 1, 32'h99, 0, 1, 0);
    chk("sclr_full_ovf", 64'(ovf_cnt), 64'(0));
    chk("sclr_full_empty", 64'(empty), 64'(1));
    step(0, 0, '0, 1, 0, 0);
    chk("rd_empty_hold", 64'(rd_data), 64'(32'h38));

    // irq disabled with a full FIFO, then bypassed hysteresis 3/5
    for (int i = 0; i < 8; i++) step(0, 1, 32'h60 + 32'(i), 0, 0, 0);
    idle(); idle();
    chk("irq_disabled", 64'(irq), 64'(0));
    thr_a = 4'd3; thr_d = 4'd5;
    idle();
    chk("bypass_irq_on", 64'(irq), 64'(1));
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0, 0);
    idle();
    chk("bypass_irq_off", 64'(irq), 64'(0));
    for (int i = 0; i < 5; i++) step(0, 1, 32'h70 + 32'(i), 0, 0, 0);

    // reset in the middle of a read
    thr_a = 4'd2; thr_d = 4'd1;
    for (int i = 0; i < 3; i++) step(0, 1, 32'h80 + 32'(i), 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 32'h99, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0);
    step(1, 0, '0, 1, 0, 0);
    chk("rst_mid_valid", 64'(rd_valid), 64'(0));
    chk("rst_mid_rdata", 64'(rd_data), 64'(0));
    chk("rst_mid_ovf", 64'(ovf_cnt), 64'(0));
    step(0, 0, '0, 0, 0, 0);
    chk("rst_mid_after", 64'(rd_valid), 64'(0));

    chk("scoreboard_drained", 64'(exp_rd.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
